// File: rtl/evu_event_streamer_if.sv
// Record stream from the event streamer toward the SPU event interface.
// The event streamer drives the master side; the consumer drives ready.
interface evu_event_streamer_if #(
  parameter int REC_W = 31
) ();
  logic             valid;
  logic             ready;
  logic [REC_W-1:0] data;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/evu_event_streamer.sv
// Multi-channel event counter that emits {channel, sat, priv, asid, count} records through a FIFO.
// Optional timestamp field appended as record LSBs when EVU_TIMESTAMP_EN is defined.
module evu_event_streamer #(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_EVENTS   = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int ASID_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TS_WIDTH     = 16,
  localparam int CA_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_EVENTS-1:0]   events_i,
  input  logic [1:0]              priv_lvl_i,
  input  logic [ASID_WIDTH-1:0]   asid_i,
  input  logic                    cfg_we_i,
  input  logic [CA_W-1:0]         cfg_addr_i,
  input  logic [31:0]             cfg_wdata_i,
  output logic [31:0]             cfg_rdata_o,
  output logic [NUM_CHANNELS-1:0] ovf_o,
  evu_event_streamer_if.master    evu
);

  localparam int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef EVU_TIMESTAMP_EN
  localparam int REC_W = 4 + 1 + 2 + ASID_WIDTH + CNT_WIDTH + TS_WIDTH;
`else
  localparam int REC_W = 4 + 1 + 2 + ASID_WIDTH + CNT_WIDTH;
`endif
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Mask bits are ordered {M, S, U}; the reserved level 2'b10 never matches.
  function automatic logic priv_ok(input logic [2:0] mask, input logic [1:0] priv);
    case (priv)
      2'b00:   return mask[0];
      2'b01:   return mask[1];
      2'b11:   return mask[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] priv_enc(input logic [1:0] priv);
    case (priv)
      2'b11:   return 2'b01;
      2'b01:   return 2'b10;
      2'b00:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + CNT_ONE : v;
  endfunction

  logic [7:0]              cfg_sel_q  [NUM_CHANNELS];
  logic [2:0]              cfg_mask_q [NUM_CHANNELS];
  logic [15:0]             cfg_thr_q  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] cfg_en_q;
  logic [CNT_WIDTH-1:0]    count_q    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending_q, sat_q, ovf_q;
  logic [1:0]              priv_snap_q [NUM_CHANNELS];
  logic [ASID_WIDTH-1:0]   asid_snap_q [NUM_CHANNELS];

  logic [CNT_WIDTH-1:0]    count_d [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    thr_eff [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] cfg_wr, hit, reach, sat_hit, set_pend, gnt;
  logic                    gnt_vld;
  logic [CA_W-1:0]         gnt_idx, rr_q;

  logic [REC_W-1:0]        mem [FIFO_DEPTH];
  logic [REC_W-1:0]        rec;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          fcnt_q;
  logic                    fifo_vld, full, push, pop, push_ok;

  logic unused_cfg;
  assign unused_cfg = ^cfg_wdata_i[15:12];

`ifdef EVU_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_snap_q [NUM_CHANNELS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + TS_WIDTH'(1);
  end
`endif

  // Per-channel hit, count and threshold evaluation
  always_comb begin
    cfg_rdata_o = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      cfg_wr[c] = cfg_we_i && (cfg_addr_i == CA_W'(c));
      if (cfg_addr_i == CA_W'(c))
        cfg_rdata_o = {cfg_thr_q[c], 4'b0000, cfg_mask_q[c], cfg_en_q[c], cfg_sel_q[c]};
      hit[c] = 1'b0;
      if (cfg_en_q[c] && (int'(cfg_sel_q[c]) < NUM_EVENTS))
        hit[c] = events_i[cfg_sel_q[c][SEL_W-1:0]] & priv_ok(cfg_mask_q[c], priv_lvl_i);
      thr_eff[c]  = (cfg_thr_q[c][CNT_WIDTH-1:0] == '0) ? CNT_ONE : cfg_thr_q[c][CNT_WIDTH-1:0];
      count_d[c]  = sat_inc(count_q[c], hit[c]);
      sat_hit[c]  = hit[c] && (count_q[c] == CNT_MAX);
      reach[c]    = hit[c] && (count_d[c] >= thr_eff[c]);
      set_pend[c] = reach[c] && !pending_q[c] && !cfg_wr[c] && !gnt[c];
    end
  end

  // Round-robin grant: lowest offset from rr_q wins, so scan offsets downward and overwrite
  assign fifo_vld = (fcnt_q != '0);
  assign full     = (fcnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop      = fifo_vld && evu.ready;
  assign push_ok  = !full || pop;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (push_ok && pending_q[(int'(rr_q) + i) % NUM_CHANNELS]) begin
        gnt_vld = 1'b1;
        gnt_idx = CA_W'((int'(rr_q) + i) % NUM_CHANNELS);
      end
    end
    for (int c = 0; c < NUM_CHANNELS; c++)
      gnt[c] = gnt_vld && (gnt_idx == CA_W'(c));
  end

  assign push = gnt_vld;
  assign rec  = {4'(gnt_idx), sat_q[gnt_idx], priv_enc(priv_snap_q[gnt_idx]),
                 asid_snap_q[gnt_idx], count_q[gnt_idx]
`ifdef EVU_TIMESTAMP_EN
                 , ts_snap_q[gnt_idx]
`endif
                };

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cfg_sel_q[c]  <= '0;
        cfg_mask_q[c] <= '0;
        cfg_thr_q[c]  <= '0;
        count_q[c]    <= '0;
      end
      cfg_en_q  <= '0;
      pending_q <= '0;
      sat_q     <= '0;
      ovf_q     <= '0;
      rr_q      <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (cfg_wr[c]) begin
          cfg_sel_q[c]  <= cfg_wdata_i[7:0];
          cfg_en_q[c]   <= cfg_wdata_i[8];
          cfg_mask_q[c] <= cfg_wdata_i[11:9];
          cfg_thr_q[c]  <= cfg_wdata_i[31:16];
          count_q[c]    <= '0;
          pending_q[c]  <= 1'b0;
          sat_q[c]      <= 1'b0;
          ovf_q[c]      <= 1'b0;
        end else if (gnt[c]) begin
          count_q[c]   <= hit[c] ? CNT_ONE : '0;
          pending_q[c] <= 1'b0;
          sat_q[c]     <= 1'b0;
        end else begin
          count_q[c] <= count_d[c];
          if (sat_hit[c]) sat_q[c] <= 1'b1;
          if (reach[c] && pending_q[c]) ovf_q[c] <= 1'b1;
          if (set_pend[c]) pending_q[c] <= 1'b1;
        end
      end
      if (gnt_vld)
        rr_q <= CA_W'((int'(gnt_idx) + 1) % NUM_CHANNELS);
    end
  end

  // Context captured when a channel becomes pending; only observed through a granted record
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (set_pend[c]) begin
        priv_snap_q[c] <= priv_lvl_i;
        asid_snap_q[c] <= asid_i;
`ifdef EVU_TIMESTAMP_EN
        ts_snap_q[c]   <= ts_q;
`endif
      end
    end
  end

  // Record FIFO: storage is registered, output is gated to zero while empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + (PTR_W+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (PTR_W+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= rec;
  end

  assign evu.valid = fifo_vld;
  assign evu.data  = fifo_vld ? mem[rd_ptr_q] : '0;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_evu_event_streamer.sv
// Directed self-checking bench for evu_event_streamer (default build, 31-bit records).
module tb_evu_event_streamer;
  localparam int REC_W = 31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] events;
  logic [1:0]  priv;
  logic [15:0] asid;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [3:0]  ovf;
  int checks = 0;
  int errors = 0;

  evu_event_streamer_if #(.REC_W(REC_W)) evu_if ();

  evu_event_streamer dut (
    .clk_i(clk), .rst_ni(rst_n), .events_i(events), .priv_lvl_i(priv), .asid_i(asid),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
    .ovf_o(ovf), .evu(evu_if)
  );

  always #5 clk = ~clk;

  function automatic logic [REC_W-1:0] rec(input int ch, input logic s, input logic [1:0] p,
                                           input logic [15:0] a, input logic [7:0] n);
    return {4'(ch), s, p, a, n};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] mask);
    events = mask;
    step();
    events = '0;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; events = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    evu_if.ready = 1'b0; priv = 2'b11; asid = '0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; events = '0; cfg_we = 1'b0; cfg_wdata = '0; evu_if.ready = 1'b0;
    priv = 2'b11; asid = '0;
    step(2);
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evu_if.valid); end
    checks++; if (evu_if.data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", evu_if.data); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", a, cfg_rdata); end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cfg_readback();
    do_reset();
    cfg_wr(2'd0, 32'h0003_0F03);
    cfg_wr(2'd3, 32'hFFFF_FFFF);
    cfg_addr = 2'd0; #1;
    checks++; if (cfg_rdata !== 32'h0003_0F03) begin errors++; $display("FAIL rdata_ch0: got %h want 00030f03", cfg_rdata); end
    cfg_addr = 2'd3; #1;
    checks++; if (cfg_rdata !== 32'hFFFF_0FFF) begin errors++; $display("FAIL rdata_ch3_unused: got %h want ffff0fff", cfg_rdata); end
    cfg_addr = 2'd1; #1;
    checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL rdata_ch1: got %h want 0", cfg_rdata); end
    cfg_addr = '0;
  endtask

  task automatic test_basic();
    logic [REC_W-1:0] exp;
    do_reset();
    priv = 2'b11; asid = 16'h005A;
    cfg_wr(2'd0, 32'h0003_0F03);
    pulse(16'h0008); step();
    pulse(16'h0008); step();
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", evu_if.valid); end
    pulse(16'h0008);
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL basic_lat_t1: got %b want 0", evu_if.valid); end
    step();
    exp = rec(0, 1'b0, 2'b01, 16'h005A, 8'd3);
    checks++; if (evu_if.valid !== 1'b1) begin errors++; $display("FAIL basic_lat_t2: got %b want 1", evu_if.valid); end
    checks++; if (evu_if.data !== exp) begin errors++; $display("FAIL basic_data: got %h want %h", evu_if.data, exp); end
    step(2);
    checks++; if (evu_if.data !== exp) begin errors++; $display("FAIL basic_hold: got %h want %h", evu_if.data, exp); end
    evu_if.ready = 1'b1;
    step();
    evu_if.ready = 1'b0;
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b want 0", evu_if.valid); end
  endtask

  task automatic test_round_robin();
    logic [REC_W-1:0] e0, e2;
    do_reset();
    priv = 2'b01; asid = 16'h0011; evu_if.ready = 1'b1;
    cfg_wr(2'd0, 32'h0001_0F00);
    cfg_wr(2'd2, 32'h0001_0F01);
    e0 = rec(0, 1'b0, 2'b10, 16'h0011, 8'd1);
    e2 = rec(2, 1'b0, 2'b10, 16'h0011, 8'd1);
    pulse(16'h0003);
    step();
    checks++; if (evu_if.data !== e0) begin errors++; $display("FAIL rr_tie1_first: got %h want %h", evu_if.data, e0); end
    step();
    checks++; if (evu_if.data !== e2) begin errors++; $display("FAIL rr_tie1_second: got %h want %h", evu_if.data, e2); end
    step();
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL rr_tie1_empty: got %b want 0", evu_if.valid); end
    pulse(16'h0001);
    step(3);
    pulse(16'h0003);
    step();
    checks++; if (evu_if.data !== e2) begin errors++; $display("FAIL rr_tie2_first: got %h want %h", evu_if.data, e2); end
    step();
    checks++; if (evu_if.data !== e0) begin errors++; $display("FAIL rr_tie2_second: got %h want %h", evu_if.data, e0); end
    step();
    evu_if.ready = 1'b0;
  endtask

  task automatic test_backlog();
    logic [REC_W-1:0] exp;
    do_reset();
    priv = 2'b11; evu_if.ready = 1'b0;
    cfg_wr(2'd1, 32'h0001_0F05);
    for (int i = 1; i <= 5; i++) begin
      asid = 16'h0100 + 16'(i);
      pulse(16'h0020);
      step(2);
    end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL backlog_no_ovf: got %b want 0000", ovf); end
    asid = 16'h0106;
    pulse(16'h0020);
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL backlog_ovf: got %b want 0010", ovf); end
    step();
    evu_if.ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp = rec(1, 1'b0, 2'b01, 16'h0100 + 16'(i), (i == 5) ? 8'd2 : 8'd1);
      checks++; if (evu_if.valid !== 1'b1 || evu_if.data !== exp) begin
        errors++; $display("FAIL backlog_drain[%0d]: got %b/%h want 1/%h", i, evu_if.valid, evu_if.data, exp);
      end
      step();
    end
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL backlog_empty: got %b want 0", evu_if.valid); end
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL backlog_ovf_sticky: got %b want 0010", ovf); end
    cfg_wr(2'd1, 32'h0001_0F05);
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL backlog_ovf_clear: got %b want 0000", ovf); end
    evu_if.ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [REC_W-1:0] exp;
    do_reset();
    priv = 2'b11; asid = 16'h0077; evu_if.ready = 1'b0;
    cfg_wr(2'd1, 32'h0001_0F05);
    for (int i = 0; i < 4; i++) begin
      pulse(16'h0020);
      step(2);
    end
    cfg_wr(2'd3, 32'hFFFF_0F07);
    events = 16'h0080;
    step(300);
    events = '0;
    checks++; if (ovf !== 4'b1000) begin errors++; $display("FAIL sat_ovf: got %b want 1000", ovf); end
    evu_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = rec(1, 1'b0, 2'b01, 16'h0077, 8'd1);
      checks++; if (evu_if.data !== exp) begin errors++; $display("FAIL sat_ch1[%0d]: got %h want %h", i, evu_if.data, exp); end
      step();
    end
    exp = rec(3, 1'b1, 2'b01, 16'h0077, 8'd255);
    checks++; if (evu_if.valid !== 1'b1 || evu_if.data !== exp) begin
      errors++; $display("FAIL sat_record: got %b/%h want 1/%h", evu_if.valid, evu_if.data, exp);
    end
    step();
    evu_if.ready = 1'b0;
  endtask

  task automatic test_priv_mask();
    logic [REC_W-1:0] exp;
    do_reset();
    priv = 2'b11; asid = 16'h0022; evu_if.ready = 1'b0;
    cfg_wr(2'd0, 32'h0003_0302);
    for (int i = 0; i < 3; i++) begin pulse(16'h0004); step(); end
    step(3);
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL mask_m_blocked: got %b want 0", evu_if.valid); end
    priv = 2'b00;
    pulse(16'h0004); step();
    pulse(16'h0004); step();
    cfg_wr(2'd0, 32'h0003_0302);
    pulse(16'h0004);
    step(3);
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL mask_cfg_clear: got %b want 0", evu_if.valid); end
    pulse(16'h0004); step();
    pulse(16'h0004);
    step();
    exp = rec(0, 1'b0, 2'b11, 16'h0022, 8'd3);
    checks++; if (evu_if.valid !== 1'b1 || evu_if.data !== exp) begin
      errors++; $display("FAIL mask_u_record: got %b/%h want 1/%h", evu_if.valid, evu_if.data, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    priv = 2'b11; asid = 16'h0033; evu_if.ready = 1'b0;
    cfg_wr(2'd1, 32'h0001_0F05);
    pulse(16'h0020); step(2);
    pulse(16'h0020); step(2);
    checks++; if (evu_if.valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", evu_if.valid); end
    rst_n = 1'b0;
    #2;
    checks++; if (evu_if.valid !== 1'b0 || evu_if.data !== '0) begin
      errors++; $display("FAIL midrst_out: got %b/%h want 0/0", evu_if.valid, evu_if.data);
    end
    cfg_addr = 2'd1; #1;
    checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL midrst_cfg: got %h want 0", cfg_rdata); end
    step();
    rst_n = 1'b1;
    step(3);
    checks++; if (evu_if.valid !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b want 0", evu_if.valid); end
  endtask

  initial begin
    rst_n = 1'b1; events = '0; priv = 2'b11; asid = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; evu_if.ready = 1'b0;
    #3;
    test_reset();
    test_cfg_readback();
    test_basic();
    test_round_robin();
    test_backlog();
    test_saturation();
    test_priv_mask();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
